// File: rtl/scene_loader_seg.sv
// scene_loader_seg
//   Turns the received byte stream into SDRAM word writes. The stream holds
//   NUM_SEGS segments. Each segment is a 4-byte big-endian word-count header
//   followed by that many words of BYTES_PER_WORD bytes each (MSB first).
//   Words go to consecutive addresses starting at BASE_ADDR. Each header is
//   announced to the scene registers on seg_start, with seg_id, seg_base and
//   seg_len.
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   byte_data, byte_valid    received byte stream (no backpressure)
//   xfer_done                end-of-transfer pulse
//   sl_addr, sl_io, sl_we    write request, held until sl_ack
//   sl_ack                   write accepted this cycle
//   seg_start, seg_id,
//   seg_base, seg_len        per-segment announcement pulse
//   sl_done                  load finished (sticky)
//   sl_err_overrun           sticky: a word was dropped under backpressure
//   sl_err_trunc             sticky: transfer ended before all segments
module scene_loader_seg #(
  parameter int BYTES_PER_WORD = 4,
  parameter int ADDR_W         = 25,
  parameter int NUM_SEGS       = 3,
  parameter int LEN_W          = 32,
  parameter int BASE_ADDR      = 0,
  parameter int SEG_W          = (NUM_SEGS > 1) ? $clog2(NUM_SEGS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  byte_data,
  input  logic                        byte_valid,
  input  logic                        xfer_done,
  output logic [ADDR_W-1:0]           sl_addr,
  output logic [8*BYTES_PER_WORD-1:0] sl_io,
  output logic                        sl_we,
  input  logic                        sl_ack,
  output logic                        seg_start,
  output logic [SEG_W-1:0]            seg_id,
  output logic [ADDR_W-1:0]           seg_base,
  output logic [LEN_W-1:0]            seg_len,
  output logic                        sl_done,
  output logic                        sl_err_overrun,
  output logic                        sl_err_trunc
);

  localparam int WW  = 8 * BYTES_PER_WORD;
  localparam int BCW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  typedef enum logic [1:0] {S_HDR, S_DATA, S_FIN, S_DONE} state_t;
  state_t state, state_nxt;

  logic [1:0]        hdr_cnt;
  logic [23:0]       hdr_sr;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  word_cnt;
  logic [BCW-1:0]    byte_cnt;
  logic [WW-1:0]     word_sr;
  logic [SEG_W-1:0]  cur_seg;
  logic [ADDR_W-1:0] wr_addr;   // address of the next write still to be accepted
  logic              xd_seen;

  logic              hdr_take, hdr_fire, data_take, word_fire, seg_end, last_seg;
  logic              stall, trunc_set;
  logic [31:0]       hdr_full;
  logic [LEN_W-1:0]  hdr_len;
  logic [WW-1:0]     word_next;
  logic [ADDR_W-1:0] next_addr;

  // Byte-level strobes and assembled values
  always_comb begin
    hdr_take  = (state == S_HDR)  && byte_valid;
    data_take = (state == S_DATA) && byte_valid;
    hdr_fire  = hdr_take && (hdr_cnt == 2'd3);
    word_fire = data_take && (byte_cnt == BCW'(BYTES_PER_WORD - 1));
    seg_end   = word_fire && ((word_cnt + LEN_W'(1)) == len);
    last_seg  = (cur_seg == SEG_W'(NUM_SEGS - 1));
    hdr_full  = {hdr_sr, byte_data};
    hdr_len   = LEN_W'(hdr_full);
    word_next = word_sr << 8;
    word_next[7:0] = byte_data;
    stall     = sl_we && !sl_ack;
    // A pending write always lands on wr_addr, so the next word goes one past it.
    next_addr = wr_addr + ADDR_W'(sl_we);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_HDR;
    else     state <= state_nxt;
  end

  // Next state: the byte is consumed first, then xfer_done is judged
  // against where that byte leaves the FSM.
  always_comb begin
    state_nxt = state;
    trunc_set = 1'b0;
    case (state)
      S_HDR:  if (hdr_fire) begin
                if (hdr_len != '0) state_nxt = S_DATA;
                else if (last_seg) state_nxt = S_FIN;
              end
      S_DATA: if (seg_end) state_nxt = last_seg ? S_FIN : S_HDR;
      S_FIN:  if (xd_seen && !sl_we) state_nxt = S_DONE;
      default: state_nxt = state;
    endcase
    // Truncation drains through FIN so a pending write still completes.
    if (xfer_done && (state_nxt == S_HDR || state_nxt == S_DATA)) begin
      trunc_set = 1'b1;
      state_nxt = S_FIN;
    end
  end

  // Outputs decoded from state
  always_comb begin
    sl_done = (state == S_DONE);
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_cnt        <= '0;
      hdr_sr         <= '0;
      len            <= '0;
      word_cnt       <= '0;
      byte_cnt       <= '0;
      word_sr        <= '0;
      cur_seg        <= '0;
      wr_addr        <= ADDR_W'(BASE_ADDR);
      xd_seen        <= 1'b0;
      sl_addr        <= ADDR_W'(BASE_ADDR);
      sl_io          <= '0;
      sl_we          <= 1'b0;
      seg_start      <= 1'b0;
      seg_id         <= '0;
      seg_base       <= ADDR_W'(BASE_ADDR);
      seg_len        <= '0;
      sl_err_overrun <= 1'b0;
      sl_err_trunc   <= 1'b0;
    end else begin
      seg_start <= 1'b0;
      xd_seen   <= xd_seen | xfer_done;
      if (sl_we && sl_ack) wr_addr <= wr_addr + ADDR_W'(1);

      if (hdr_take) begin
        hdr_sr  <= {hdr_sr[15:0], byte_data};
        hdr_cnt <= hdr_cnt + 2'd1;
      end
      if (hdr_fire) begin
        len       <= hdr_len;
        word_cnt  <= '0;
        byte_cnt  <= '0;
        seg_start <= 1'b1;
        seg_id    <= cur_seg;
        seg_base  <= next_addr;
        seg_len   <= hdr_len;
        if (hdr_len == '0 && !last_seg) cur_seg <= cur_seg + SEG_W'(1);
      end

      if (data_take) begin
        word_sr  <= word_next;
        byte_cnt <= word_fire ? '0 : byte_cnt + BCW'(1);
      end
      // A dropped word still counts so the next header lands where expected.
      if (word_fire) begin
        word_cnt <= seg_end ? '0 : word_cnt + LEN_W'(1);
        if (seg_end && !last_seg) cur_seg <= cur_seg + SEG_W'(1);
        if (stall) sl_err_overrun <= 1'b1;
      end

      if (word_fire && !stall) begin
        sl_we   <= 1'b1;
        sl_io   <= word_next;
        sl_addr <= next_addr;
      end else if (sl_we && sl_ack) begin
        sl_we <= 1'b0;
      end

      if (trunc_set) sl_err_trunc <= 1'b1;
    end
  end

endmodule

// File: tb/tb_scene_loader_seg.sv
module tb_scene_loader_seg;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  byte_data;
  logic        byte_valid, xfer_done, sl_ack;
  logic [24:0] sl_addr, seg_base;
  logic [31:0] sl_io, seg_len;
  logic        sl_we, seg_start, sl_done, ovr, trunc;
  logic [1:0]  seg_id;

  logic [7:0]  b2_data;
  logic        b2_valid, xd2, ack2;
  logic [24:0] a2_addr, a2_base;
  logic [15:0] a2_io;
  logic [31:0] a2_len;
  logic        a2_we, a2_ss, a2_done, a2_ovr, a2_trunc;
  logic [1:0]  a2_id;

  int n_checks = 0;
  int n_fail   = 0;

  logic [24:0] wq_addr[$];
  logic [31:0] wq_data[$];
  logic [1:0]  sq_id[$];
  logic [24:0] sq_base[$];
  logic [31:0] sq_len[$];
  logic [24:0] w2_addr[$];
  logic [15:0] w2_data[$];
  logic [24:0] s2_base[$];
  logic [31:0] s2_len[$];

  always #5 clk = ~clk;

  scene_loader_seg dut (
    .clk(clk), .rst(rst), .byte_data(byte_data), .byte_valid(byte_valid),
    .xfer_done(xfer_done), .sl_addr(sl_addr), .sl_io(sl_io), .sl_we(sl_we),
    .sl_ack(sl_ack), .seg_start(seg_start), .seg_id(seg_id), .seg_base(seg_base),
    .seg_len(seg_len), .sl_done(sl_done), .sl_err_overrun(ovr), .sl_err_trunc(trunc));

  scene_loader_seg #(.BYTES_PER_WORD(2), .BASE_ADDR('h100)) dut2 (
    .clk(clk), .rst(rst), .byte_data(b2_data), .byte_valid(b2_valid),
    .xfer_done(xd2), .sl_addr(a2_addr), .sl_io(a2_io), .sl_we(a2_we),
    .sl_ack(ack2), .seg_start(a2_ss), .seg_id(a2_id), .seg_base(a2_base),
    .seg_len(a2_len), .sl_done(a2_done), .sl_err_overrun(a2_ovr), .sl_err_trunc(a2_trunc));

  // Record accepted writes and segment announcements mid-cycle.
  always @(negedge clk) begin
    if (sl_we && sl_ack) begin wq_addr.push_back(sl_addr); wq_data.push_back(sl_io); end
    if (seg_start) begin sq_id.push_back(seg_id); sq_base.push_back(seg_base); sq_len.push_back(seg_len); end
    if (a2_we && ack2) begin w2_addr.push_back(a2_addr); w2_data.push_back(a2_io); end
    if (a2_ss) begin s2_base.push_back(a2_base); s2_len.push_back(a2_len); end
  end

  task automatic do_reset();
    rst = 1'b1; byte_data = '0; byte_valid = 1'b0; xfer_done = 1'b0; sl_ack = 1'b0;
    b2_data = '0; b2_valid = 1'b0; xd2 = 1'b0; ack2 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wq_addr.delete(); wq_data.delete(); sq_id.delete(); sq_base.delete(); sq_len.delete();
    w2_addr.delete(); w2_data.delete(); s2_base.delete(); s2_len.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1 byte_data = b; byte_valid = 1'b1;
    @(posedge clk); #1 byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  task automatic send_byte2(input logic [7:0] b);
    @(posedge clk); #1 b2_data = b; b2_valid = 1'b1;
    @(posedge clk); #1 b2_valid = 1'b0;
  endtask

  task automatic pulse_xfer();
    @(posedge clk); #1 xfer_done = 1'b1;
    @(posedge clk); #1 xfer_done = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!sl_done && n < 50) begin @(posedge clk); #1; n++; end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (sl_we !== 1'b0) begin n_fail++; $display("FAIL rst_we got %0b exp 0", sl_we); end
    n_checks++; if (sl_addr !== 25'h0) begin n_fail++; $display("FAIL rst_addr got %h exp 0", sl_addr); end
    n_checks++; if (sl_io !== 32'h0) begin n_fail++; $display("FAIL rst_io got %h exp 0", sl_io); end
    n_checks++; if (seg_start !== 1'b0) begin n_fail++; $display("FAIL rst_seg_start got %0b exp 0", seg_start); end
    n_checks++; if (seg_len !== 32'h0) begin n_fail++; $display("FAIL rst_seg_len got %h exp 0", seg_len); end
    n_checks++; if ({sl_done, ovr, trunc} !== 3'b000) begin n_fail++; $display("FAIL rst_flags got %b exp 000", {sl_done, ovr, trunc}); end
    n_checks++; if (a2_addr !== 25'h100) begin n_fail++; $display("FAIL rst_addr2 got %h exp 100", a2_addr); end
  endtask

  task automatic test_basic();
    logic [1:0]  eid[3]  = '{2'd0, 2'd1, 2'd2};
    logic [24:0] ebase[3] = '{25'd0, 25'd2, 25'd2};
    logic [31:0] elen[3]  = '{32'd2, 32'd0, 32'd1};
    logic [31:0] edat[3]  = '{32'h11223344, 32'h55667788, 32'hAABBCCDD};
    do_reset();
    sl_ack = 1'b1;
    send_word(32'd2); send_word(32'h11223344); send_word(32'h55667788);
    send_word(32'd0);
    send_word(32'd1); send_word(32'hAABBCCDD);
    for (int i = 0; i < 20; i++) send_byte(8'h1A);
    pulse_xfer();
    wait_done();
    n_checks++; if (sq_id.size() !== 3) begin n_fail++; $display("FAIL basic_seg_count got %0d exp 3", sq_id.size()); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (sq_id[i] !== eid[i] || sq_base[i] !== ebase[i] || sq_len[i] !== elen[i]) begin
        n_fail++; $display("FAIL basic_seg%0d got (%0d,%h,%0d) exp (%0d,%h,%0d)", i, sq_id[i], sq_base[i], sq_len[i], eid[i], ebase[i], elen[i]);
      end
    end
    n_checks++; if (wq_addr.size() !== 3) begin n_fail++; $display("FAIL basic_write_count got %0d exp 3", wq_addr.size()); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (wq_addr[i] !== 25'(i) || wq_data[i] !== edat[i]) begin
        n_fail++; $display("FAIL basic_wr%0d got %h@%h exp %h@%h", i, wq_data[i], wq_addr[i], edat[i], i);
      end
    end
    n_checks++; if (sl_done !== 1'b1) begin n_fail++; $display("FAIL basic_done got %0b exp 1", sl_done); end
    n_checks++; if ({ovr, trunc} !== 2'b00) begin n_fail++; $display("FAIL basic_errs got %b exp 00", {ovr, trunc}); end
  endtask

  task automatic test_backpressure();
    logic [31:0] w = 32'hDEADBEEF;
    do_reset();
    send_word(32'd2);
    for (int i = 3; i >= 1; i--) begin send_byte(w[8*i +: 8]); repeat (8) @(posedge clk); #1; end
    send_byte(w[7:0]);
    n_checks++; if (sl_we !== 1'b1 || sl_io !== w || sl_addr !== 25'd0) begin n_fail++; $display("FAIL bp_first got we=%0b %h@%h exp we=1 %h@0", sl_we, sl_io, sl_addr, w); end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_checks++; if (sl_we !== 1'b1 || sl_io !== w || sl_addr !== 25'd0) begin n_fail++; $display("FAIL bp_hold%0d got we=%0b %h@%h exp we=1 %h@0", c, sl_we, sl_io, sl_addr, w); end
    end
    sl_ack = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (sl_we !== 1'b0) begin n_fail++; $display("FAIL bp_we_drop got %0b exp 0", sl_we); end
    send_word(32'h01020304);
    repeat (2) @(posedge clk); #1;
    n_checks++; if (wq_addr.size() !== 2) begin n_fail++; $display("FAIL bp_write_count got %0d exp 2", wq_addr.size()); end
    n_checks++; if (wq_addr[0] !== 25'd0 || wq_data[0] !== w) begin n_fail++; $display("FAIL bp_wr0 got %h@%h exp %h@0", wq_data[0], wq_addr[0], w); end
    n_checks++; if (wq_addr[1] !== 25'd1 || wq_data[1] !== 32'h01020304) begin n_fail++; $display("FAIL bp_wr1 got %h@%h exp 01020304@1", wq_data[1], wq_addr[1]); end
    n_checks++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL bp_overrun got %0b exp 0", ovr); end
  endtask

  task automatic test_overrun();
    do_reset();
    send_word(32'd3);
    send_word(32'h10203040);
    send_word(32'h50607080);
    n_checks++; if (ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_flag got %0b exp 1", ovr); end
    n_checks++; if (sl_we !== 1'b1 || sl_io !== 32'h10203040 || sl_addr !== 25'd0) begin n_fail++; $display("FAIL ovr_pending got we=%0b %h@%h exp we=1 10203040@0", sl_we, sl_io, sl_addr); end
    sl_ack = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (sl_we !== 1'b0) begin n_fail++; $display("FAIL ovr_we_drop got %0b exp 0", sl_we); end
    send_word(32'h90A0B0C0);
    send_word(32'd1);
    send_word(32'h0A0B0C0D);
    repeat (3) @(posedge clk); #1;
    n_checks++; if (wq_addr.size() !== 3) begin n_fail++; $display("FAIL ovr_write_count got %0d exp 3", wq_addr.size()); end
    n_checks++; if (wq_data[0] !== 32'h10203040 || wq_addr[0] !== 25'd0) begin n_fail++; $display("FAIL ovr_wr0 got %h@%h exp 10203040@0", wq_data[0], wq_addr[0]); end
    n_checks++; if (wq_data[1] !== 32'h90A0B0C0 || wq_addr[1] !== 25'd1) begin n_fail++; $display("FAIL ovr_wr1 got %h@%h exp 90A0B0C0@1", wq_data[1], wq_addr[1]); end
    n_checks++; if (wq_data[2] !== 32'h0A0B0C0D || wq_addr[2] !== 25'd2) begin n_fail++; $display("FAIL ovr_wr2 got %h@%h exp 0A0B0C0D@2", wq_data[2], wq_addr[2]); end
    n_checks++; if (sq_id[1] !== 2'd1 || sq_base[1] !== 25'd2 || sq_len[1] !== 32'd1) begin n_fail++; $display("FAIL ovr_seg1 got (%0d,%h,%0d) exp (1,2,1)", sq_id[1], sq_base[1], sq_len[1]); end
  endtask

  task automatic test_trunc();
    do_reset();
    sl_ack = 1'b1;
    send_word(32'd2);
    send_word(32'h11223344);
    send_byte(8'h55);
    pulse_xfer();
    wait_done();
    n_checks++; if (wq_addr.size() !== 1 || wq_data[0] !== 32'h11223344) begin n_fail++; $display("FAIL trunc_writes got n=%0d %h exp n=1 11223344", wq_addr.size(), wq_data[0]); end
    n_checks++; if (trunc !== 1'b1) begin n_fail++; $display("FAIL trunc_flag got %0b exp 1", trunc); end
    n_checks++; if (sl_done !== 1'b1) begin n_fail++; $display("FAIL trunc_done got %0b exp 1", sl_done); end
    n_checks++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL trunc_overrun got %0b exp 0", ovr); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_word(32'd1);
    send_word(32'hCAFEF00D);
    n_checks++; if (sl_we !== 1'b1) begin n_fail++; $display("FAIL rmid_we_before got %0b exp 1", sl_we); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (sl_we !== 1'b0 || sl_addr !== 25'd0 || sl_io !== 32'd0) begin n_fail++; $display("FAIL rmid_after got we=%0b %h@%h exp we=0 0@0", sl_we, sl_io, sl_addr); end
    rst = 1'b0; sl_ack = 1'b1;
    wq_addr.delete(); wq_data.delete(); sq_id.delete(); sq_base.delete(); sq_len.delete();
    send_word(32'd1);
    send_word(32'h12345678);
    repeat (2) @(posedge clk); #1;
    n_checks++; if (wq_addr.size() !== 1 || wq_addr[0] !== 25'd0 || wq_data[0] !== 32'h12345678) begin n_fail++; $display("FAIL rmid_write got n=%0d %h@%h exp n=1 12345678@0", wq_addr.size(), wq_data[0], wq_addr[0]); end
    n_checks++; if (sq_id[0] !== 2'd0 || sq_base[0] !== 25'd0 || sq_len[0] !== 32'd1) begin n_fail++; $display("FAIL rmid_seg got (%0d,%h,%0d) exp (0,0,1)", sq_id[0], sq_base[0], sq_len[0]); end
  endtask

  task automatic test_bpw2();
    logic [7:0] s[14] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'hBE, 8'hEF,
                          8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    int n = 0;
    do_reset();
    ack2 = 1'b1;
    for (int i = 0; i < 14; i++) send_byte2(s[i]);
    @(posedge clk); #1 xd2 = 1'b1;
    @(posedge clk); #1 xd2 = 1'b0;
    while (!a2_done && n < 50) begin @(posedge clk); #1; n++; end
    n_checks++; if (w2_addr.size() !== 1 || w2_addr[0] !== 25'h100 || w2_data[0] !== 16'hBEEF) begin n_fail++; $display("FAIL bpw2_write got n=%0d %h@%h exp n=1 BEEF@100", w2_addr.size(), w2_data[0], w2_addr[0]); end
    n_checks++; if (s2_base.size() !== 3 || s2_base[0] !== 25'h100 || s2_len[0] !== 32'd1 || s2_base[2] !== 25'h101) begin n_fail++; $display("FAIL bpw2_segs got n=%0d base0=%h len0=%0d base2=%h exp n=3 100 1 101", s2_base.size(), s2_base[0], s2_len[0], s2_base[2]); end
    n_checks++; if (a2_done !== 1'b1 || a2_ovr !== 1'b0 || a2_trunc !== 1'b0) begin n_fail++; $display("FAIL bpw2_flags got done=%0b ovr=%0b trunc=%0b exp 1 0 0", a2_done, a2_ovr, a2_trunc); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overrun();
    test_trunc();
    test_reset_mid();
    test_bpw2();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/scene_loader_seg.md
# scene_loader_seg

Parametrised, segment-aware scene loader between the XMODEM receiver and the SDRAM write port. Consumes the received byte stream as NUM_SEGS segments, each a 4-byte big-endian word-count header followed by that many data words. Packs each data word from BYTES_PER_WORD bytes and writes it to consecutive SDRAM addresses from BASE_ADDR. Announces each segment's base address and length to the scene registers, and holds each write until SDRAM acknowledges it.

## Interface
Parameters:
- BYTES_PER_WORD, 4, bytes per SDRAM word (1..8)
- ADDR_W, 25, SDRAM word-address width
- NUM_SEGS, 3, segment count (kd-tree, lists, triangles)
- LEN_W, 32, header length width (≤32; header bits above LEN_W ignored)
- BASE_ADDR, 0, first write address
- SEG_W, max(1,$clog2(NUM_SEGS)), derived; segment id width

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- byte_data  in  8  received byte
- byte_valid  in  1  byte_data valid this cycle; at most one byte per cycle, no backpressure
- xfer_done  in  1  transfer complete pulse (EOT)
- sl_addr  out  ADDR_W  write word address
- sl_io  out  8*BYTES_PER_WORD  write data; first-received byte in MSBs
- sl_we  out  1  write request, held until accepted
- sl_ack  in  1  write accepted this cycle when sl_we=1
- seg_start  out  1  one-cycle pulse: header decoded
- seg_id  out  SEG_W  segment index for seg_start
- seg_base  out  ADDR_W  address of the segment's first word
- seg_len  out  LEN_W  segment length in words
- sl_done  out  1  load finished (sticky until rst)
- sl_err_overrun  out  1  sticky: word dropped under backpressure
- sl_err_trunc  out  1  sticky: xfer_done before all segments complete

## Operation
- States: HDR (collect 4 header bytes), DATA (collect words), FIN (all segments complete), DONE.
- HDR: header bytes shift in big-endian. On the 4th byte, latch len, then pulse seg_start with seg_id=cur seg, seg_base=next write addr, seg_len=len.
  - len≠0 -> DATA.
  - len=0 -> next segment's HDR, or FIN if it was the last segment.
- DATA: byte counter mod BYTES_PER_WORD; bytes shift into word register MSB-first.
  - On word completion: load the pending write (sl_io, sl_addr), then increment the word count.
  - When word count reaches len: advance seg_id, go to HDR, or go to FIN after segment NUM_SEGS-1.
- Write address: starts at BASE_ADDR, increments by 1 on each accepted write (sl_we&sl_ack), wraps modulo 2^ADDR_W. Segments are contiguous.
- Overrun: a word completes while sl_we=1 and sl_ack=0 that cycle.
  - The new word is dropped and sl_err_overrun sets.
  - The pending write is unchanged.
  - The word still counts toward len, so segment framing is preserved.
- FIN: further byte_valid is ignored (XMODEM 0x1A padding).
- DONE: entered when xfer_done has been seen (latched) AND the state is FIN AND sl_we=0. sl_done=1 from then on.
- Truncation: xfer_done in HDR or DATA sets sl_err_trunc.
  - Any pending write still completes; partial words and headers are discarded.
  - Then DONE, with sl_done=1.
- Reset values: sl_we=0, seg_start=0, seg_id=0, seg_base=BASE_ADDR, seg_len=0, sl_addr=BASE_ADDR, sl_io=0, sl_done=0, both error flags 0, state HDR, all counters 0.

## Timing
- Word/header completion on byte cycle N:
  - sl_we=1 with valid sl_addr/sl_io at N+1.
  - seg_start pulses at N+1, for exactly 1 cycle.
- sl_we stays high until the cycle sl_ack=1. It is low the next cycle unless a new word completed on the ack cycle, in which case it stays high with the new data/address (no overrun).
- sl_addr/sl_io are stable while sl_we=1 and sl_ack=0.
- sl_done rises the cycle after the DONE condition holds.
- Error flags rise the cycle after the causing event.
- xfer_done coincident with the last byte of the last segment is not truncation. The last byte is processed first, then xfer_done.
- rst mid-transfer: all outputs at reset values the cycle after rst is sampled high. Any pending write is abandoned.

## Test plan
- BPW=4, NUM_SEGS=3, sl_ack tied 1.
  - Stream: hdr 2, words 0x11223344 and 0x55667788; hdr 0; hdr 1, word 0xAABBCCDD; then 20 bytes 0x1A; then xfer_done.
  - Required: seg_start ×3 with (id,base,len) = (0,0,2), (1,2,0), (2,2,1).
  - Required writes: addr0=0x11223344, addr1=0x55667788, addr2=0xAABBCCDD.
  - Required: no 4th write, sl_done=1, no errors.
- Backpressure: sl_ack held 0 for 3 cycles on the first write (bytes spaced 10 cycles apart). sl_we and data stay stable until ack. Address increments only on ack. No overrun.
- Overrun: sl_ack=0 while a second word completes.
  - sl_err_overrun=1; the first word is written once after ack; the second word is dropped.
  - The next segment's header still decodes at the correct byte offset.
- Truncation: xfer_done after 5 of 8 bytes of a 2-word segment. One write occurs, sl_err_trunc=1, sl_done=1.
- Reset: rst asserted mid-DATA with sl_we=1.
  - Next cycle: sl_we=0, sl_addr=BASE_ADDR, state HDR.
  - A fresh stream then loads from BASE_ADDR.
- BPW=2, BASE_ADDR=0x100: hdr 1 with bytes 0xBE 0xEF gives one write, addr 0x100 = 0xBEEF.
